// File: rtl/sd_clk_div_calc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sd_clk_div_calc
// Brief    : SD clock divide-count calculator (TRAN_SPEED or direct Hz) with
//            iterative restoring divider and ceiling rounding.
// Revision : 1.0 - initial release
// ============================================================================
module sd_clk_div_calc #(
    parameter int unsigned REF_CLK_HZ  = 50_000_000,
    parameter int          COUNT_W     = 16,
    parameter int          DIV_MODE    = 0,
    parameter int unsigned RESET_COUNT = 125
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [7:0]         tran_speed,
    input  logic [31:0]        rate_hz,
    output logic               busy,
    output logic               ok,
    output logic               err,
    output logic               sat,
    output logic               clk_div_reset,
    output logic [COUNT_W-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_DIVIDE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [32:0] c_count_max = (33'd1 << COUNT_W) - 33'd1;

    state_t r_state;
    state_t w_state_nxt;

    logic        r_mode;
    logic [7:0]  r_ts;
    logic [31:0] r_rate;

    logic [32:0] r_divisor;
    logic [31:0] r_dividend;
    logic [31:0] r_quot;
    logic [32:0] r_rem;
    logic [4:0]  r_iter;

    logic               r_ok;
    logic               r_err;
    logic               r_sat;
    logic               r_cdr;
    logic [COUNT_W-1:0] r_count;

    logic [6:0]  w_mult;
    logic [23:0] w_unit;
    logic [31:0] w_ts_rate;
    logic        w_ts_err;
    logic [31:0] w_rate;
    logic        w_req_err;
    logic [32:0] w_divisor;
    logic [33:0] w_rem_sh;
    logic        w_ge;
    logic [32:0] w_diff;
    logic [32:0] w_q_ceil;
    logic        w_sat;
    logic        w_accept;

    // TRAN_SPEED: mantissa x10 in [6:3], decade unit in [2:0]
    always_comb begin
        w_mult = 7'd0;
        case (r_ts[6:3])
            4'h1: w_mult = 7'd10;
            4'h2: w_mult = 7'd12;
            4'h3: w_mult = 7'd13;
            4'h4: w_mult = 7'd15;
            4'h5: w_mult = 7'd20;
            4'h6: w_mult = 7'd25;
            4'h7: w_mult = 7'd30;
            4'h8: w_mult = 7'd35;
            4'h9: w_mult = 7'd40;
            4'hA: w_mult = 7'd45;
            4'hB: w_mult = 7'd50;
            4'hC: w_mult = 7'd55;
            4'hD: w_mult = 7'd60;
            4'hE: w_mult = 7'd70;
            4'hF: w_mult = 7'd80;
            default: w_mult = 7'd0;
        endcase
        w_unit = 24'd0;
        case (r_ts[2:0])
            3'd0:    w_unit = 24'd10_000;
            3'd1:    w_unit = 24'd100_000;
            3'd2:    w_unit = 24'd1_000_000;
            3'd3:    w_unit = 24'd10_000_000;
            default: w_unit = 24'd0;
        endcase
    end

    assign w_ts_rate = 32'(w_mult) * 32'(w_unit);
    assign w_ts_err  = r_ts[7] | (r_ts[6:3] == 4'd0) | (r_ts[2:0] >= 3'd4);
    assign w_rate    = r_mode ? r_rate : w_ts_rate;
    assign w_req_err = r_mode ? (r_rate == 32'd0) : w_ts_err;
    assign w_divisor = {1'b0, w_rate} << DIV_MODE;

    // Remainder may reach 33 bits, so the trial compare needs 34
    assign w_rem_sh = {r_rem, r_dividend[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
    assign w_diff   = w_rem_sh[32:0] - r_divisor;

    assign w_q_ceil = {1'b0, r_quot} + {32'd0, (r_rem != 33'd0)};
    assign w_sat    = (w_q_ceil > c_count_max);
    assign w_accept = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_req_err ? S_IDLE : S_DIVIDE;
            S_DIVIDE: if (r_iter == 5'd31) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode     <= 1'b0;
            r_ts       <= 8'd0;
            r_rate     <= 32'd0;
            r_divisor  <= 33'd0;
            r_dividend <= 32'd0;
            r_quot     <= 32'd0;
            r_rem      <= 33'd0;
            r_iter     <= 5'd0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_sat      <= 1'b0;
            r_cdr      <= 1'b0;
            r_count    <= COUNT_W'(RESET_COUNT);
        end else begin
            r_ok  <= (r_state == S_FINISH);
            r_err <= (r_state == S_DECODE) && w_req_err;
            r_cdr <= r_ok;
            if (w_accept) begin
                r_mode <= mode;
                r_ts   <= tran_speed;
                r_rate <= rate_hz;
            end
            case (r_state)
                S_DECODE: begin
                    r_divisor  <= w_divisor;
                    r_dividend <= 32'(REF_CLK_HZ);
                    r_quot     <= 32'd0;
                    r_rem      <= 33'd0;
                    r_iter     <= 5'd0;
                end
                S_DIVIDE: begin
                    r_rem      <= w_ge ? w_diff : w_rem_sh[32:0];
                    r_quot     <= {r_quot[30:0], w_ge};
                    r_dividend <= {r_dividend[30:0], 1'b0};
                    r_iter     <= r_iter + 5'd1;
                end
                S_FINISH: begin
                    r_sat   <= w_sat;
                    r_count <= w_sat ? c_count_max[COUNT_W-1:0] : w_q_ceil[COUNT_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign ok            = r_ok;
    assign err           = r_err;
    assign sat           = r_sat;
    assign clk_div_reset = r_cdr;
    assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sd_clk_div_calc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sd_clk_div_calc
// Brief    : Scoreboard bench driving three calculator configurations in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_clk_div_calc;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [7:0]  ts;
    logic [31:0] rate;

    logic [N-1:0] busy, ok, err, sat, cdr;
    logic [15:0]  cnt0, cnt1;
    logic [7:0]   cnt2;
    logic [31:0]  cnt [N];

    assign cnt[0] = {16'd0, cnt0};
    assign cnt[1] = {16'd0, cnt1};
    assign cnt[2] = {24'd0, cnt2};

    always #5 clk = ~clk;

    sd_clk_div_calc #(.REF_CLK_HZ(50_000_000), .COUNT_W(16), .DIV_MODE(0), .RESET_COUNT(125)) u_d0 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .tran_speed(ts), .rate_hz(rate),
        .busy(busy[0]), .ok(ok[0]), .err(err[0]), .sat(sat[0]), .clk_div_reset(cdr[0]), .count(cnt0));
    sd_clk_div_calc #(.REF_CLK_HZ(50_000_000), .COUNT_W(16), .DIV_MODE(1), .RESET_COUNT(125)) u_d1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .tran_speed(ts), .rate_hz(rate),
        .busy(busy[1]), .ok(ok[1]), .err(err[1]), .sat(sat[1]), .clk_div_reset(cdr[1]), .count(cnt1));
    sd_clk_div_calc #(.REF_CLK_HZ(50_000_000), .COUNT_W(8), .DIV_MODE(0), .RESET_COUNT(125)) u_d2 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .tran_speed(ts), .rate_hz(rate),
        .busy(busy[2]), .ok(ok[2]), .err(err[2]), .sat(sat[2]), .clk_div_reset(cdr[2]), .count(cnt2));

    typedef struct {
        int     c;
        bit     s;
        bit     e;
        longint t0;
    } exp_t;

    exp_t sbq [N][$];
    int   last_cnt [N];
    bit   cdr_pend [N];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input int d, input longint act, input longint expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, expv);
    endtask

    // Monitor: pops one expectation per ok/err and checks latency from accept
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < N; d++) begin
                if (cdr_pend[d]) begin
                    chk("clk_div_reset", d, longint'(cdr[d]), 1);
                    cdr_pend[d] = 1'b0;
                end else if (cdr[d]) begin
                    chk("spurious_clk_div_reset", d, 1, 0);
                end
                if (ok[d] && err[d]) chk("ok_err_excl", d, 1, 0);
                if (ok[d] || err[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk("unexpected_result", d, 1, 0);
                    end else begin
                        exp_t   e;
                        longint lat;
                        e   = sbq[d].pop_front();
                        lat = ($time - e.t0) / 10;
                        chk("err_flag", d, longint'(err[d]), longint'(e.e));
                        if (e.e) begin
                            chk("err_latency", d, lat, 1);
                            chk("count_kept", d, longint'(cnt[d]), longint'(last_cnt[d]));
                        end else begin
                            chk("ok_latency", d, lat, 34);
                            chk("count", d, longint'(cnt[d]), longint'(e.c));
                            chk("sat", d, longint'(sat[d]), longint'(e.s));
                            last_cnt[d] = e.c;
                            cdr_pend[d] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input bit now, input bit m, input logic [7:0] t, input logic [31:0] r,
                         input bit push, input int c0, input int c1, input int c2,
                         input bit s0, input bit s1, input bit s2, input bit e);
        longint t0;
        if (!now) @(negedge clk);
        start = 1'b1; mode = m; ts = t; rate = r;
        @(posedge clk);
        t0 = $time;
        if (push) begin
            sbq[0].push_back('{c0, s0, e, t0});
            sbq[1].push_back('{c1, s1, e, t0});
            sbq[2].push_back('{c2, s2, e, t0});
        end
        @(negedge clk);
        // scramble inputs to prove they were latched at accept
        start = 1'b0; mode = ~m; ts = 8'hFF; rate = 32'd0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq[0].size() != 0 || sbq[1].size() != 0 || sbq[2].size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("result_timeout", 0, 1, 0);
                for (int d = 0; d < N; d++) sbq[d].delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input bit m, input logic [7:0] t, input logic [31:0] r,
                       input int c0, input int c1, input int c2,
                       input bit s0, input bit s1, input bit s2, input bit e);
        issue(1'b0, m, t, r, 1'b1, c0, c1, c2, s0, s1, s2, e);
        wait_idle();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mode = 1'b0; ts = 8'd0; rate = 32'd0;
        for (int d = 0; d < N; d++) begin
            last_cnt[d] = 125;
            cdr_pend[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            chk("reset_count", d, longint'(cnt[d]), 125);
            chk("reset_busy", d, longint'(busy[d]), 0);
            chk("reset_ok", d, longint'(ok[d]), 0);
            chk("reset_err", d, longint'(err[d]), 0);
            chk("reset_sat", d, longint'(sat[d]), 0);
            chk("reset_cdr", d, longint'(cdr[d]), 0);
        end
        reset = 1'b0;
        @(negedge clk);

        //  mode  ts     rate           d0     d1     d2   s0 s1 s2 err
        run(1'b0, 8'h32, 32'd0,          2,     1,     2,  0, 0, 0, 0);
        run(1'b0, 8'h5A, 32'd0,          1,     1,     1,  0, 0, 0, 0);
        run(1'b1, 8'h00, 32'd400_000,  125,    63,   125,  0, 0, 0, 0);
        run(1'b1, 8'h00, 32'd300_000,  167,    84,   167,  0, 0, 0, 0);
        run(1'b1, 8'h00, 32'd100_000,  500,   250,   255,  0, 0, 1, 0);
        run(1'b0, 8'h32, 32'd0,          2,     1,     2,  0, 0, 0, 0);
        run(1'b0, 8'h02, 32'd0,          0,     0,     0,  0, 0, 0, 1);
        run(1'b0, 8'h35, 32'd0,          0,     0,     0,  0, 0, 0, 1);
        run(1'b0, 8'hB2, 32'd0,          0,     0,     0,  0, 0, 0, 1);
        run(1'b1, 8'h32, 32'd0,          0,     0,     0,  0, 0, 0, 1);
        run(1'b1, 8'h00, 32'd1,      65535, 65535,   255,  1, 1, 1, 0);
        run(1'b0, 8'h7B, 32'd0,          1,     1,     1,  0, 0, 0, 0);
        run(1'b1, 8'h00, 32'hFFFF_FFFF,  1,     1,     1,  0, 0, 0, 0);
        run(1'b0, 8'h2A, 32'd0,          3,     2,     3,  0, 0, 0, 0);
        run(1'b0, 8'h0F, 32'd0,          0,     0,     0,  0, 0, 0, 1);

        // start while busy must be dropped
        issue(1'b0, 1'b0, 8'h32, 32'd0, 1'b1, 2, 1, 2, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        start = 1'b1; mode = 1'b1; rate = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // back-to-back: second start in the cycle ok is high
        issue(1'b0, 1'b0, 8'h2A, 32'd0, 1'b1, 3, 2, 3, 0, 0, 0, 0);
        n = 0;
        while (!ok[0] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_ok_seen", 0, longint'(ok[0]), 1);
        issue(1'b1, 1'b0, 8'h32, 32'd0, 1'b1, 2, 1, 2, 0, 0, 0, 0);
        wait_idle();

        // reset at E10 of a run: no result, count back to reset value
        issue(1'b0, 1'b1, 8'h00, 32'd300_000, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < N; d++) begin
            chk("abort_count", d, longint'(cnt[d]), 125);
            chk("abort_busy", d, longint'(busy[d]), 0);
            last_cnt[d] = 125;
            cdr_pend[d] = 1'b0;
        end
        repeat (45) @(negedge clk);

        run(1'b0, 8'h32, 32'd0,          2,     1,     2,  0, 0, 0, 0);

        for (int d = 0; d < N; d++) chk("queue_drained", d, longint'(sbq[d].size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
